spike_event_logger: RTL and testbench

// - Downstream consumer of the two-neuron LIF/STDP core. Timestamps spike pulses

---
 rtl/spike_event_logger_pkg.sv | 18 +
 rtl/spike_event_logger_if.sv | 13 +
 rtl/spike_evt_fifo.sv | 60 ++++++
 rtl/spike_event_logger.sv | 107 ++++++++++
 tb/tb_spike_event_logger.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/spike_event_logger_pkg.sv
// Shared event-word definitions for the spike logger: source codes, word width, packing helper.
// Pure declarations; no latency or flow-control behaviour.
package snn_pkg;

    localparam int EV_WIDTH = 8;
    localparam int EV_TS_WIDTH = EV_WIDTH - 2;

    localparam logic [1:0] SRC_WRAP = 2'b00;
    localparam logic [1:0] SRC_PRE  = 2'b01;
    localparam logic [1:0] SRC_POST = 2'b10;
    localparam logic [1:0] SRC_BOTH = 2'b11;

    function automatic logic [EV_WIDTH-1:0] ev_word(input logic [1:0] src,
                                                    input logic [EV_TS_WIDTH-1:0] ts);
        return {src, ts};
    endfunction

endpackage

// File: rtl/spike_event_logger_if.sv
// Event drain stream: valid/ready handshake carrying one {src, ts} word per transfer.
// The logger drives master; the host-side consumer uses slave.
interface spike_event_logger_if;
    import snn_pkg::*;

    logic                ev_valid;
    logic                ev_ready;
    logic [EV_WIDTH-1:0] ev_data;

    modport master (output ev_valid, output ev_data, input ev_ready);
    modport slave  (input ev_valid, input ev_data, output ev_ready);

endinterface

// File: rtl/spike_evt_fifo.sv
// Synchronous FIFO; head is read straight from registered storage, so a push is visible one cycle later.
// A push into a full FIFO is taken only when a pop frees a slot on the same edge.
module spike_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        // Same slot index, opposite lap bit: writer is a full lap ahead.
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        head     = mem_q[rd_ptr_q[AW-1:0]];

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/spike_event_logger.sv
// Timestamps pre/post spike pulses into {src, ts} words; an event is visible on ev one cycle after capture.
// Stalled consumers fill the FIFO; further events are dropped and counted (sticky overflow, saturating drop_cnt).
module spike_event_logger
    import snn_pkg::*;
#(
    parameter int TS_WIDTH   = 6,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clear,
    input  logic                  spike_pre,
    input  logic                  spike_post,
    spike_event_logger_if.master  ev,
    output logic                  overflow,
    output logic [3:0]            drop_cnt
);
    localparam logic [7:0]          PS_LAST = 8'(PRESCALE - 1);
    localparam logic [TS_WIDTH-1:0] TS_MAX  = '1;

    logic [7:0]          ps_cnt_q, ps_cnt_d;
    logic [TS_WIDTH-1:0] ts_q, ts_d;
    logic                wrap_pend_q, wrap_pend_d;
    logic                overflow_q, overflow_d;
    logic [3:0]          drop_cnt_q, drop_cnt_d;

    logic                flush;
    logic                tick;
    logic                push;
    logic                pop;
    logic                drop;
    logic [1:0]          src;
    logic [EV_WIDTH-1:0] push_word;
    logic [EV_WIDTH-1:0] fifo_head;
    logic                fifo_empty;
    logic                fifo_full;

    always_comb begin
        flush     = rst || clear;
        tick      = en && (ps_cnt_q == PS_LAST);
        // Bit 0 = pre, bit 1 = post; no spike leaves SRC_WRAP, which is what a marker carries.
        src       = {spike_post, spike_pre};
        // wrap_pend_q is only ever set while ts is (about to be) zero, so no ts compare is needed.
        push      = en && (spike_pre || spike_post || wrap_pend_q);
        push_word = ev_word(src, ts_q);
        pop       = !fifo_empty && ev.ev_ready;
        drop      = push && fifo_full && !pop;

        ps_cnt_d = ps_cnt_q;
        if (en) begin
            ps_cnt_d = tick ? 8'd0 : ps_cnt_q + 8'd1;
        end
        ts_d = tick ? ts_q + TS_WIDTH'(1) : ts_q;

        wrap_pend_d = wrap_pend_q;
        if (push || tick) begin
            wrap_pend_d = 1'b0;
        end
        if (tick && (ts_q == TS_MAX)) begin
            wrap_pend_d = 1'b1;
        end

        overflow_d = overflow_q || drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 4'hF)) begin
            drop_cnt_d = drop_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            ps_cnt_q    <= '0;
            ts_q        <= '0;
            wrap_pend_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            ps_cnt_q    <= ps_cnt_d;
            ts_q        <= ts_d;
            wrap_pend_q <= wrap_pend_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    spike_evt_fifo #(
        .WIDTH (EV_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (flush),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_data  = fifo_head;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_spike_event_logger.sv
// Scoreboard bench: a cycle-level reference model predicts accepted events into a queue;
// a negedge monitor compares every handshake and the status outputs against it.
module tb_spike_event_logger;
    import snn_pkg::*;

    localparam int DEPTH    = 4;
    localparam int PRESCALE = 1;
    localparam int TSW      = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic       spike_pre = 1'b0;
    logic       spike_post = 1'b0;
    logic       overflow;
    logic [3:0] drop_cnt;

    spike_event_logger_if ev_if();

    spike_event_logger #(
        .TS_WIDTH   (TSW),
        .FIFO_DEPTH (DEPTH),
        .PRESCALE   (PRESCALE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clear      (clear),
        .spike_pre  (spike_pre),
        .spike_post (spike_post),
        .ev         (ev_if),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;

    // Reference model state: state as it stands during the current cycle.
    logic [7:0] exp_q[$];
    int         mcnt = 0;
    int         ticks = 0;
    int         psc = 0;
    bit         due = 1'b0;
    bit         m_ovf = 1'b0;
    int         m_drop = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Predict the effect of the next clock edge from the inputs currently applied.
    task automatic model_step();
        bit         pop;
        bit         push;
        int         ts;
        logic [1:0] s;
        logic [5:0] ts6;
        if (rst || clear) begin
            mcnt = 0; exp_q.delete(); ticks = 0; psc = 0;
            due = 1'b0; m_ovf = 1'b0; m_drop = 0;
            return;
        end
        pop  = (mcnt > 0) && ev_if.ev_ready;
        ts   = ticks % 64;
        push = 1'b0;
        s    = 2'd0;
        if (en) begin
            if (spike_pre || spike_post) begin
                push = 1'b1;
                s = (spike_pre && spike_post) ? 2'd3 : (spike_post ? 2'd2 : 2'd1);
            end else if (due && ts == 0) begin
                push = 1'b1;
            end
        end
        if (push) begin
            due = 1'b0;
            ts6 = 6'(ts);
            if (mcnt < DEPTH || pop) begin
                exp_q.push_back({s, ts6});
                mcnt++;
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 15) m_drop++;
            end
        end
        if (pop) mcnt--;
        if (en) begin
            psc++;
            if (psc == PRESCALE) begin
                psc = 0;
                if (ts == 63) due = 1'b1;
                ticks++;
            end
        end
    endtask

    task automatic drive(input bit r, input bit c, input bit e, input bit pr,
                         input bit po, input bit rd);
        @(posedge clk); #1;
        rst = r; clear = c; en = e; spike_pre = pr; spike_post = po;
        ev_if.ev_ready = rd;
        @(negedge clk); #1;
        model_step();
    endtask

    // Directed check of what the DUT shows right now; d < 0 skips the data compare.
    task automatic expect_now(input string n, input bit v, input int d);
        check({n, "_valid"}, int'(ev_if.ev_valid), int'(v));
        if (d >= 0) check({n, "_data"}, int'(ev_if.ev_data), d);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("mon_valid", int'(ev_if.ev_valid), int'(mcnt > 0));
            check("mon_overflow", int'(overflow), int'(m_ovf));
            check("mon_drop_cnt", int'(drop_cnt), m_drop);
            if (ev_if.ev_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_data: got unexpected event %02h, expected none", ev_if.ev_data);
                end else begin
                    check("mon_data", int'(ev_if.ev_data), int'(exp_q[0]));
                    if (ev_if.ev_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        ev_if.ev_ready = 1'b0;
        drive(1, 0, 0, 0, 0, 1);
        mon_en = 1'b1;
        drive(0, 0, 0, 0, 0, 1);
        expect_now("reset", 0, 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_drop_cnt", int'(drop_cnt), 0);

        // T1: pre spike at ts=5
        repeat (5) drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 1, 0, 1);
        drive(0, 0, 1, 0, 0, 1);
        expect_now("t1_pre_ts5", 1, 8'b01_000101);

        // T2: simultaneous pre+post at ts=9
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 1, 1, 0);
        drive(0, 0, 1, 0, 0, 0);
        expect_now("t2_both_ts9", 1, 8'b11_001001);
        repeat (3) drive(0, 0, 0, 0, 0, 1);

        // T3: wrap marker, then wrap implied by a post spike at ts=0
        drive(0, 1, 0, 0, 0, 0);
        repeat (64) drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        expect_now("t3_wrap_marker", 1, 8'h00);
        repeat (3) drive(0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 0);
        repeat (64) drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 1, 0);
        drive(0, 0, 1, 0, 0, 0);
        expect_now("t3_post_ts0", 1, 8'b10_000000);
        drive(0, 0, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 0, 0);
        expect_now("t3_no_marker", 0, -1);

        // T4: overflow with six spikes into a stalled 4-deep buffer
        drive(0, 1, 0, 0, 0, 0);
        repeat (6) drive(0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        expect_now("t4_head", 1, 8'h40);
        check("t4_overflow", int'(overflow), 1);
        check("t4_drop_cnt", int'(drop_cnt), 2);
        repeat (5) drive(0, 0, 0, 0, 0, 1);
        expect_now("t4_drained", 0, -1);

        // T5: push into full buffer with a simultaneous pop
        repeat (4) drive(0, 0, 1, 1, 0, 0);
        drive(0, 0, 1, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        expect_now("t5_head", 1, 8'h47);
        check("t5_drop_cnt", int'(drop_cnt), 2);
        repeat (6) drive(0, 0, 0, 0, 0, 1);

        // T6: clear with 3 queued at ts=20, then en=0 behaviour
        drive(0, 1, 0, 0, 0, 0);
        repeat (7) drive(0, 0, 1, 1, 0, 0);
        drive(0, 0, 1, 0, 0, 1);
        repeat (12) drive(0, 0, 1, 0, 0, 0);
        drive(0, 1, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        expect_now("t6_cleared", 0, 0);
        check("t6_overflow", int'(overflow), 0);
        check("t6_drop_cnt", int'(drop_cnt), 0);
        drive(0, 0, 1, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        expect_now("t6_ts_zero", 1, 8'h40);
        repeat (5) drive(0, 0, 0, 1, 1, 0);
        drive(0, 0, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 0, 0);
        expect_now("t6_en0_frozen", 1, 8'h81);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 127) == 0), ($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 9) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1));
        end

        n = 0;
        while (ev_if.ev_valid && n < 16) begin
            drive(0, 0, 0, 0, 0, 1);
            n++;
        end
        expect_now("final_drain", 0, -1);
        check("final_scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
